alu_share_arbiter: RTL

//  Shares the single combinational MIPS ALU between two requesters: req0 is the

---
 rtl/alu_share_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational MIPS ALU between two requesters.
// Define ALU_OPCHK_EN to answer opcodes above 5'b00110 with an illegal response instead of using the ALU.
module alu_share_arbiter #(
    parameter int DATAWIDTH = 32,
    parameter int CTRLW     = 6
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [DATAWIDTH-1:0] req0_a,
    input  logic [DATAWIDTH-1:0] req0_b,
    input  logic [CTRLW-1:0]     req0_alucont,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [DATAWIDTH-1:0] req1_a,
    input  logic [DATAWIDTH-1:0] req1_b,
    input  logic [CTRLW-1:0]     req1_alucont,
    output logic                 rsp0_valid,
    input  logic                 rsp0_ready,
    output logic [DATAWIDTH-1:0] rsp0_result,
    output logic                 rsp0_overflow,
    output logic                 rsp0_illegal,
    output logic                 rsp1_valid,
    input  logic                 rsp1_ready,
    output logic [DATAWIDTH-1:0] rsp1_result,
    output logic                 rsp1_overflow,
    output logic                 rsp1_illegal,
    output logic [DATAWIDTH-1:0] alu_a,
    output logic [DATAWIDTH-1:0] alu_b,
    output logic [CTRLW-1:0]     alu_alucont,
    input  logic [DATAWIDTH-1:0] alu_result,
    input  logic                 alu_overflow
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t               state_q, state_d;
    logic                 rr_q, rr_d, owner_q, owner_d;
    logic [DATAWIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d, res_q, res_d;
    logic [CTRLW-1:0]     op_c_q, op_c_d;
    logic                 ovf_q, ovf_d, ill_q, ill_d;
    logic                 grant, accept, op_illegal;
    logic [DATAWIDTH-1:0] sel_a, sel_b;
    logic [CTRLW-1:0]     sel_c;

    // NOTE: every signal gets a default at the top of a comb block so no path can infer a latch.
    always_comb begin
        grant = rr_q;
        if (req0_valid && !req1_valid) grant = 1'b0;
        else if (req1_valid && !req0_valid) grant = 1'b1;
        sel_a  = grant ? req1_a : req0_a;
        sel_b  = grant ? req1_b : req0_b;
        sel_c  = grant ? req1_alucont : req0_alucont;
        accept = reset_n && (state_q == IDLE) && (grant ? req1_valid : req0_valid);
    end

`ifdef ALU_OPCHK_EN
    assign op_illegal = (sel_c[4:0] > 5'b00110);
`else
    assign op_illegal = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = op_illegal ? RESP : EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (owner_q ? rsp1_ready : rsp0_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rr_d    = rr_q;
        owner_d = owner_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        op_c_d  = op_c_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        ill_d   = ill_q;
        if (accept) begin
            owner_d = grant;
            op_a_d  = sel_a;
            op_b_d  = sel_b;
            op_c_d  = sel_c;
            ill_d   = op_illegal;
            if (op_illegal) begin
                res_d = '0;
                ovf_d = 1'b0;
            end
        end
        if (state_q == EXEC) begin
            res_d = alu_result;
            ovf_d = alu_overflow;
        end
        // Pointer moves only when a response completes, handing priority to the other side.
        if (state_q == RESP && state_d == IDLE) rr_d = ~owner_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_q    <= 1'b0;
            owner_q <= 1'b0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            op_c_q  <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            rr_q    <= rr_d;
            owner_q <= owner_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            op_c_q  <= op_c_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            ill_q   <= ill_d;
        end
    end

    always_comb begin
        req0_ready = accept && !grant;
        req1_ready = accept && grant;
        rsp0_valid = (state_q == RESP) && !owner_q;
        rsp1_valid = (state_q == RESP) && owner_q;
    end

    assign alu_a         = op_a_q;
    assign alu_b         = op_b_q;
    assign alu_alucont   = op_c_q;
    assign rsp0_result   = res_q;
    assign rsp1_result   = res_q;
    assign rsp0_overflow = ovf_q;
    assign rsp1_overflow = ovf_q;
    assign rsp0_illegal  = ill_q;
    assign rsp1_illegal  = ill_q;
endmodule
